ex_fwd_stage: RTL and testbench
===============================

Name: ex_fwd_stage

Overview:
- ID/EX pipeline stage of the 5-stage MIPS core.
- Registers the decoded operands, tracks destination registers down to MEM/WB, and produces registered 2-bit selects for the two 32-bit 4-input ALU operand muxes directly downstream.
- Detects load-use hazards and requests a one-cycle stall.
- Handles branch flush by inserting a bubble.

Parameters:
- DW, 32, operand data width.
- RW, 5, register-number width.

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  decode stage holds a real instruction
- id_rs  in  RW  source register A number
- id_rt  in  RW  source register B number
- id_uses_rt  in  1  instruction reads rt as a source
- id_dst  in  RW  destination register number
- id_reg_write  in  1  instruction writes the register file
- id_mem_read  in  1  instruction is a load
- id_alu_src  in  1  operand B is the immediate
- id_rs_data  in  DW  register file read A
- id_rt_data  in  DW  register file read B
- id_imm  in  DW  sign-extended immediate
- flush  in  1  branch taken; kill the ID instruction
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- ex_rs_data  out  DW  registered rs data, mux in0 for A
- ex_rt_data  out  DW  registered rt data, mux in0 for B
- ex_imm  out  DW  registered immediate, mux in3 for B
- sel_a  out  2  registered select for the A mux
- sel_b  out  2  registered select for the B mux
- ex_valid  out  1  EX stage holds a real instruction

Behaviour:
- Internal state:
  - ID/EX: ex_valid, ex_dst, ex_reg_write, ex_mem_read, plus the data outputs.
  - EX/MEM: m_valid, m_dst, m_reg_write.
  - MEM/WB: w_valid, w_dst, w_reg_write.
- Reset (async, immediate): all valid bits 0, all reg_write and mem_read 0, all dst 0, all data outputs 0, sel_a and sel_b = 2'b00. stall reads 0 while in reset.
- Every clock, unconditionally: MEM/WB <= EX/MEM; EX/MEM <= ID/EX (valid, dst, reg_write).
- ID/EX load:
  - If flush=1 or stall=1, load a bubble: valid=0, reg_write=0, mem_read=0, sels=00, data fields 0.
  - Otherwise capture all id_* inputs and the computed selects.
- hz(r, v, w, d) is true when r != 0, v = 1, w = 1 and d == r.
- stall = id_valid & ~flush & ex_mem_read & (hz(id_rs, ex_valid, ex_reg_write, ex_dst) | (id_uses_rt & hz(id_rt, ex_valid, ex_reg_write, ex_dst))).
- flush takes priority over stall: the killed instruction never stalls.
- Next sel_a, computed from the current ID/EX and EX/MEM contents:
  - 01 if hz(id_rs, ex_valid, ex_reg_write, ex_dst). That instruction will be in EX/MEM when the consumer is in EX.
  - else 10 if hz(id_rs, m_valid, m_reg_write, m_dst).
  - else 00.
  - The younger producer always wins.
- Next sel_b:
  - 11 if id_alu_src.
  - else the same rule as sel_a using id_rt, gated by id_uses_rt; if id_uses_rt = 0 then 00.
- Mux encoding: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB result, 11 immediate.
- Load-use case: after the one-cycle stall, the load sits in EX/MEM with a bubble ahead of it. The consumer therefore gets sel 10 and takes the loaded value from MEM/WB.
- Register 0 is never forwarded and never causes a stall.
- Producers older than MEM/WB are not tracked. The register file is write-before-read, so regfile data is already correct.
- id_valid = 0 is captured as a bubble: valid=0, reg_write forced 0, sels 00.
- Latency: one clock from ID inputs to ex_* and sel_* outputs.

Optional Feature:
- Macro FWD_PERF_CNT_EN.
- When defined, adds outputs stall_cnt [31:0] and fwd_cnt [31:0].
  - Both reset to 0 and wrap modulo 2^32.
  - stall_cnt increments on every clock with stall=1.
  - fwd_cnt increments on every clock where ID/EX loads a valid instruction whose next sel_a is in {01, 10} or next sel_b is in {01, 10}; a case with both counts once.
- When undefined, neither the ports nor the logic exist, and all other behaviour is identical.

Test Plan:
- Reset, then rst asserted mid-stream with valid instructions in flight -> all valids 0, sel_a = sel_b = 00 and stall = 0 on the same cycle, independent of clk.
- add r3 followed by sub r4,r3,r5 -> sub in EX with sel_a = 01 and sel_b = 00; stall never asserted.
- add r3, nop, or r6,r3,r3 -> or in EX with sel_a = 10 and sel_b = 10.
- lw r2 followed by add r7,r2,r1 -> stall = 1 for exactly one cycle and a bubble enters EX; add then enters EX with sel_a = 10.
- add r0 followed by sub r4,r0,r0 -> sel_a = sel_b = 00, no stall.
- lw r2 followed by add r7,r2,r1 with flush = 1 on that cycle -> stall = 0, bubble in EX. Also: addi r8,r3,5 after add r3 -> sel_a = 01, sel_b = 11.

Source files
------------

// File: rtl/ex_fwd_stage.sv
// ID/EX stage: registers operands, tracks EX/MEM destination, computes forwarding selects and load-use stall.
// Latency: one clock from id_* to ex_*/sel_*; stall is combinational. Backpressure: stall holds PC and IF/ID.
// Optional FWD_PERF_CNT_EN adds stall_cnt and fwd_cnt counters.
module ex_fwd_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_uses_rt,
    input  logic [RW-1:0] id_dst,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_alu_src,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic          flush,
    output logic          stall,
    output logic [DW-1:0] ex_rs_data,
    output logic [DW-1:0] ex_rt_data,
    output logic [DW-1:0] ex_imm,
    output logic [1:0]    sel_a,
    output logic [1:0]    sel_b,
    output logic          ex_valid
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   fwd_cnt
`endif
);

    logic [RW-1:0] ex_dst;
    logic          ex_reg_write;
    logic          ex_mem_read;
    // MEM/WB needs no tracking: the regfile is write-before-read, so that producer is already visible.
    logic          m_valid;
    logic [RW-1:0] m_dst;
    logic          m_reg_write;

    logic          hz_a_ex, hz_a_m, hz_b_ex, hz_b_m;
    logic [1:0]    sel_a_nxt, sel_b_nxt;
    logic          load;

    function automatic logic hz(input logic [RW-1:0] r, input logic v, input logic w,
                                input logic [RW-1:0] d);
        return (r != '0) && v && w && (d == r);
    endfunction

    always_comb begin
        hz_a_ex   = hz(id_rs, ex_valid, ex_reg_write, ex_dst);
        hz_a_m    = hz(id_rs, m_valid, m_reg_write, m_dst);
        hz_b_ex   = hz(id_rt, ex_valid, ex_reg_write, ex_dst);
        hz_b_m    = hz(id_rt, m_valid, m_reg_write, m_dst);
        sel_a_nxt = 2'b00;
        sel_b_nxt = 2'b00;
        // Younger producer (now in EX) wins over the older one (now in MEM).
        if (hz_a_ex)
            sel_a_nxt = 2'b01;
        else if (hz_a_m)
            sel_a_nxt = 2'b10;
        if (id_alu_src)
            sel_b_nxt = 2'b11;
        else if (id_uses_rt && hz_b_ex)
            sel_b_nxt = 2'b01;
        else if (id_uses_rt && hz_b_m)
            sel_b_nxt = 2'b10;
    end

    assign stall = ~rst & id_valid & ~flush & ex_mem_read & (hz_a_ex | (id_uses_rt & hz_b_ex));
    assign load  = id_valid & ~flush & ~stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_dst       <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_rs_data   <= '0;
            ex_rt_data   <= '0;
            ex_imm       <= '0;
            sel_a        <= 2'b00;
            sel_b        <= 2'b00;
            m_valid      <= 1'b0;
            m_dst        <= '0;
            m_reg_write  <= 1'b0;
        end else begin
            m_valid     <= ex_valid;
            m_dst       <= ex_dst;
            m_reg_write <= ex_reg_write;
            if (load) begin
                ex_valid     <= 1'b1;
                ex_dst       <= id_dst;
                ex_reg_write <= id_reg_write;
                ex_mem_read  <= id_mem_read;
                ex_rs_data   <= id_rs_data;
                ex_rt_data   <= id_rt_data;
                ex_imm       <= id_imm;
                sel_a        <= sel_a_nxt;
                sel_b        <= sel_b_nxt;
            end else begin
                ex_valid     <= 1'b0;
                ex_dst       <= '0;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
                ex_rs_data   <= '0;
                ex_rt_data   <= '0;
                ex_imm       <= '0;
                sel_a        <= 2'b00;
                sel_b        <= 2'b00;
            end
        end
    end

`ifdef FWD_PERF_CNT_EN
    logic fwd_hit;
    assign fwd_hit = load & ((sel_a_nxt == 2'b01) | (sel_a_nxt == 2'b10) |
                             (sel_b_nxt == 2'b01) | (sel_b_nxt == 2'b10));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall)
                stall_cnt <= stall_cnt + 32'd1;
            if (fwd_hit)
                fwd_cnt <= fwd_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_fwd_stage.sv
// Bench for ex_fwd_stage: directed pipeline scenarios plus random traffic against a producer-age model.
module tb_ex_fwd_stage;
    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_uses_rt, id_reg_write, id_mem_read, id_alu_src, flush;
    logic [RW-1:0] id_rs, id_rt, id_dst;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic          stall, ex_valid;
    logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [1:0]    sel_a, sel_b;
`ifdef FWD_PERF_CNT_EN
    logic [31:0]   stall_cnt, fwd_cnt;
`endif

    ex_fwd_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_dst(id_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_alu_src(id_alu_src), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm), .flush(flush), .stall(stall),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .sel_a(sel_a), .sel_b(sel_b), .ex_valid(ex_valid)
`ifdef FWD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        valid;
        bit [4:0]  dst;
        bit        rw;
        bit        mr;
        bit [31:0] a, b, imm;
        bit [1:0]  sa, sb;
    } ins_t;

    ins_t        pipe[$];          // pipe[0] = instruction in EX, pipe[1] = one stage older
    int          errors = 0;
    int          checks = 0;
    int unsigned m_stall_cnt = 0;
    int unsigned m_fwd_cnt = 0;
    logic        last_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Age of the youngest in-flight writer of r: 1 = in EX, 2 = one stage older, 0 = none tracked.
    function automatic int prod_age(input bit [4:0] r);
        if (r == 5'd0) return 0;
        for (int k = 0; k < 2; k++)
            if (pipe[k].valid && pipe[k].rw && pipe[k].dst == r) return k + 1;
        return 0;
    endfunction

    task automatic model_reset();
        ins_t z;
        z = '{default: '0};
        pipe.delete();
        pipe.push_back(z);
        pipe.push_back(z);
        m_stall_cnt = 0;
        m_fwd_cnt = 0;
    endtask

    task automatic drive(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit ut,
                         input bit [4:0] d, input bit rw, input bit mr, input bit als, input bit fl);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = ut; id_dst = d;
        id_reg_write = rw; id_mem_read = mr; id_alu_src = als; flush = fl;
        id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    endtask

    // Called at a negedge with inputs driven; checks stall, clocks once, checks EX outputs.
    task automatic step();
        ins_t nx;
        bit   exp_st;
        int   aa, ab;
        #1;
        aa = prod_age(id_rs);
        ab = id_uses_rt ? prod_age(id_rt) : 0;
        exp_st = id_valid && !flush && pipe[0].mr && (aa == 1 || ab == 1);
        last_stall = stall;
        chk("stall", {31'd0, stall}, {31'd0, exp_st});
        nx = '{default: '0};
        if (id_valid && !flush && !exp_st) begin
            nx.valid = 1'b1; nx.dst = id_dst; nx.rw = id_reg_write; nx.mr = id_mem_read;
            nx.a = id_rs_data; nx.b = id_rt_data; nx.imm = id_imm;
            nx.sa = 2'(aa);
            nx.sb = id_alu_src ? 2'b11 : 2'(ab);
            if (aa != 0 || (!id_alu_src && ab != 0)) m_fwd_cnt++;
        end
        if (exp_st) m_stall_cnt++;
        @(posedge clk);
        #1;
        pipe.push_front(nx);
        void'(pipe.pop_back());
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, pipe[0].valid});
        chk("sel_a", {30'd0, sel_a}, {30'd0, pipe[0].sa});
        chk("sel_b", {30'd0, sel_b}, {30'd0, pipe[0].sb});
        chk("ex_rs_data", ex_rs_data, pipe[0].a);
        chk("ex_rt_data", ex_rt_data, pipe[0].b);
        chk("ex_imm", ex_imm, pipe[0].imm);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_sel_a", {30'd0, sel_a}, 32'd0);
        chk("rst_sel_b", {30'd0, sel_b}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_ex_imm", ex_imm, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // add r3 ; sub r4,r3,r5
        drive(1, 1, 2, 1, 3, 1, 0, 0, 0); step();
        drive(1, 3, 5, 1, 4, 1, 0, 0, 0); step();
        chk("fwd1_sel_a", {30'd0, sel_a}, 32'd1);
        chk("fwd1_sel_b", {30'd0, sel_b}, 32'd0);
        chk("fwd1_stall", {31'd0, last_stall}, 32'd0);

        // add r3 ; nop ; or r6,r3,r3
        drive(1, 1, 2, 1, 3, 1, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        drive(1, 3, 3, 1, 6, 1, 0, 0, 0); step();
        chk("fwd2_sel_a", {30'd0, sel_a}, 32'd2);
        chk("fwd2_sel_b", {30'd0, sel_b}, 32'd2);

        // lw r2 ; add r7,r2,r1 (stalls once, then forwards from MEM/WB)
        drive(1, 1, 0, 0, 2, 1, 1, 1, 0); step();
        drive(1, 2, 1, 1, 7, 1, 0, 0, 0); step();
        chk("lu_stall", {31'd0, last_stall}, 32'd1);
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        drive(1, 2, 1, 1, 7, 1, 0, 0, 0); step();
        chk("lu_stall_gone", {31'd0, last_stall}, 32'd0);
        chk("lu_sel_a", {30'd0, sel_a}, 32'd2);
        chk("lu_valid", {31'd0, ex_valid}, 32'd1);

        // add r0 ; sub r4,r0,r0
        drive(1, 1, 2, 1, 0, 1, 0, 0, 0); step();
        drive(1, 0, 0, 1, 4, 1, 0, 0, 0); step();
        chk("r0_sel_a", {30'd0, sel_a}, 32'd0);
        chk("r0_sel_b", {30'd0, sel_b}, 32'd0);
        chk("r0_stall", {31'd0, last_stall}, 32'd0);

        // lw r2 ; add r7,r2,r1 killed by flush
        drive(1, 1, 0, 0, 2, 1, 1, 1, 0); step();
        drive(1, 2, 1, 1, 7, 1, 0, 0, 1); step();
        chk("fl_stall", {31'd0, last_stall}, 32'd0);
        chk("fl_bubble", {31'd0, ex_valid}, 32'd0);

        // add r3 ; addi r8,r3,5
        drive(1, 1, 2, 1, 3, 1, 0, 0, 0); step();
        drive(1, 3, 0, 0, 8, 1, 0, 1, 0); step();
        chk("imm_sel_a", {30'd0, sel_a}, 32'd1);
        chk("imm_sel_b", {30'd0, sel_b}, 32'd3);

        // Reset mid-stream with a load in EX and a dependent consumer in ID
        drive(1, 1, 0, 0, 2, 1, 1, 1, 0); step();
        drive(1, 2, 1, 1, 7, 1, 0, 0, 0);
        #1;
        chk("pre_rst_stall", {31'd0, stall}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("mid_rst_sel_a", {30'd0, sel_a}, 32'd0);
        chk("mid_rst_sel_b", {30'd0, sel_b}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Random traffic on a small register window to provoke many hazards
        for (int n = 0; n < 500; n++) begin
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
            step();
        end

`ifdef FWD_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, m_stall_cnt);
        chk("fwd_cnt", fwd_cnt, m_fwd_cnt);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
